// File: rtl/mmx_operand_stage_pkg.sv
// Shared types and constants for the MMX operand-supply stage.
// Optional macro: MMX_WB_BYPASS_EN (write-then-read on capture).
package mmx_operand_stage_pkg;

  localparam int MM_W = 64;

  localparam logic [2:0] PADDW = 3'b000;
  localparam logic [2:0] PADDD = 3'b001;
  localparam logic [2:0] PMAX  = 3'b010;
  localparam logic [2:0] PMIN  = 3'b011;
  localparam logic [2:0] MOVQ  = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE,
    S_REQ_LO,
    S_WAIT_LO,
    S_REQ_HI,
    S_WAIT_HI,
    S_HOLD
  } state_t;

endpackage

// File: rtl/mmx_operand_stage_regfile.sv
// Eight 64-bit MMX registers, two async read ports, one write port.
// MMX_WB_BYPASS_EN forwards same-cycle write data to the read ports.
module mmx_regfile
  import mmx_operand_stage_pkg::*;
#(
  parameter int NUM_MM = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            we,
  input  logic [2:0]      widx,
  input  logic [MM_W-1:0] wdata,
  input  logic [2:0]      ra0,
  input  logic [2:0]      ra1,
  output logic [MM_W-1:0] rd0,
  output logic [MM_W-1:0] rd1
);

  logic [MM_W-1:0] mem [NUM_MM];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_MM; i++)
        mem[i] <= '0;
    end else if (we) begin
      mem[widx] <= wdata;
    end
  end

`ifdef MMX_WB_BYPASS_EN
  assign rd0 = (we && widx == ra0) ? wdata : mem[ra0];
  assign rd1 = (we && widx == ra1) ? wdata : mem[ra1];
`else
  assign rd0 = mem[ra0];
  assign rd1 = mem[ra1];
`endif

endmodule

// File: rtl/mmx_operand_stage.sv
// MMX operand stage: register/memory operand fetch, valid/ready to execute.
// Optional macro: MMX_WB_BYPASS_EN (see mmx_regfile).
module mmx_operand_stage
  import mmx_operand_stage_pkg::*;
#(
  parameter int NUM_MM = 8,
  parameter int BEAT_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [2:0]        in_op,
  input  logic [2:0]        in_dst,
  input  logic [2:0]        in_src,
  input  logic              in_src_mem,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_beat,
  input  logic              mem_rsp_valid,
  input  logic [BEAT_W-1:0] mem_rsp_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [MM_W-1:0]   out_mm,
  output logic [MM_W-1:0]   out_mm64,
  output logic [2:0]        out_op,
  output logic [2:0]        out_dst,
  input  logic              wb_en,
  input  logic [2:0]        wb_idx,
  input  logic [MM_W-1:0]   wb_data
);

  state_t state_q, state_n;
  logic [MM_W-1:0] rd_dst, rd_src;
  logic accept;

  mmx_regfile #(.NUM_MM(NUM_MM)) u_rf (
    .clk   (clk),
    .reset (reset),
    .we    (wb_en),
    .widx  (wb_idx),
    .wdata (wb_data),
    .ra0   (in_dst),
    .ra1   (in_src),
    .rd0   (rd_dst),
    .rd1   (rd_src)
  );

  assign in_ready = (state_q == S_IDLE) ||
                    (state_q == S_HOLD && out_ready);
  assign accept   = in_valid && in_ready;

  assign out_valid     = (state_q == S_HOLD);
  assign mem_req_valid = (state_q == S_REQ_LO) ||
                         (state_q == S_REQ_HI);
  assign mem_req_beat  = (state_q == S_REQ_HI);

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      S_IDLE:
        if (accept)
          state_n = in_src_mem ? S_REQ_LO : S_HOLD;
      S_REQ_LO:
        if (mem_req_ready) state_n = S_WAIT_LO;
      S_WAIT_LO:
        if (mem_rsp_valid) state_n = S_REQ_HI;
      S_REQ_HI:
        if (mem_req_ready) state_n = S_WAIT_HI;
      S_WAIT_HI:
        if (mem_rsp_valid) state_n = S_HOLD;
      S_HOLD:
        if (accept)
          state_n = in_src_mem ? S_REQ_LO : S_HOLD;
        else if (out_ready)
          state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
  end

  // Operands are snapshots: later writes never reach captured data.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      out_mm   <= '0;
      out_mm64 <= '0;
      out_op   <= '0;
      out_dst  <= '0;
    end else begin
      state_q <= state_n;
      if (accept) begin
        out_op  <= in_op;
        out_dst <= in_dst;
        out_mm  <= rd_dst;
        if (!in_src_mem)
          out_mm64 <= rd_src;
      end
      if (state_q == S_WAIT_LO && mem_rsp_valid)
        out_mm64[BEAT_W-1:0] <= mem_rsp_data;
      if (state_q == S_WAIT_HI && mem_rsp_valid)
        out_mm64[2*BEAT_W-1:BEAT_W] <= mem_rsp_data;
    end
  end

endmodule
